// File: rtl/prog_load_ctrl.sv
// Bring-up sequencer for the 32-bit core: writes Rk=k into the register file, streams a program
// into instruction memory, runs the core until HALT or timeout, then dumps the first registers.
module prog_load_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int REG_AW    = 5,
    parameter int DUMP_REGS = 6,
    parameter int TIMEOUT   = 4096,
    parameter int CNT_W     = 16
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] prog_len,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              cpu_run,
    input  logic              cpu_halted,
    output logic              dump_valid,
    output logic [REG_AW-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    input  logic              dump_ready,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic [CNT_W-1:0]  cycles,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_LOAD, S_RUN, S_DUMP, S_DONE} state_e;

    localparam logic [REG_AW-1:0] REG_LAST  = '1;
    localparam logic [REG_AW-1:0] DUMP_LAST = REG_AW'(DUMP_REGS - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [REG_AW-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] j_q, j_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              timed_out_q, timed_out_d;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            j_q         <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cycles_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            j_q         <= j_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cycles_q    <= cycles_d;
            timed_out_q <= timed_out_d;
        end
    end

    // LOAD stays one extra cycle after the last word is taken so its registered write
    // is presented before cpu_run rises.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_INIT;
            S_INIT: if (idx_q == REG_LAST) state_d = (len_q == '0) ? S_RUN : S_LOAD;
            S_LOAD: if (j_q == len_q) state_d = S_RUN;
            S_RUN:  if (cpu_halted || cycles_q == TIMEOUT_C) state_d = S_DUMP;
            S_DUMP: if (dump_ready && idx_q == DUMP_LAST) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshakes: a word moves only in a cycle where valid and ready are both high; the
    // producer holds valid and data stable until then, and the consumer may stall freely.
    always_comb begin
        idx_d       = idx_q;
        len_d       = len_q;
        j_d         = j_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        cycles_d    = cycles_q;
        timed_out_d = timed_out_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    idx_d       = '0;
                    len_d       = prog_len;
                    j_d         = '0;
                    cycles_d    = '0;
                    timed_out_d = 1'b0;
                end
            end
            S_INIT: idx_d = idx_q + REG_AW'(1);
            S_LOAD: begin
                if (src_valid && src_ready) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = j_q;
                    mem_wdata_d = src_data;
                    j_d         = j_q + ADDR_W'(1);
                end
            end
            S_RUN:  if (!cpu_halted && cycles_q == TIMEOUT_C) timed_out_d = 1'b1;
            S_DUMP: if (dump_ready) idx_d = idx_q + REG_AW'(1);
            default: ;
        endcase
        if (state_d == S_RUN && state_q != S_RUN) begin
            cycles_d = CNT_W'(1);
        end else if (state_d == S_RUN) begin
            cycles_d = cycles_q + CNT_W'(1);
        end
    end

    always_comb begin
        src_ready  = (state_q == S_LOAD) && (j_q != len_q);
        reg_we     = (state_q == S_INIT);
        reg_addr   = (state_q == S_INIT || state_q == S_DUMP) ? idx_q : '0;
        reg_wdata  = (state_q == S_INIT) ? DATA_W'(idx_q) : '0;
        cpu_run    = (state_q == S_RUN);
        dump_valid = (state_q == S_DUMP);
        dump_idx   = (state_q == S_DUMP) ? idx_q : '0;
        dump_data  = (state_q == S_DUMP) ? reg_rdata : '0;
        busy       = (state_q != S_IDLE) && (state_q != S_DONE);
        done       = (state_q == S_DONE);
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cycles    = cycles_q;
    assign timed_out = timed_out_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Bench for prog_load_ctrl: a small core/register-file model plus expected queues for the
// register writes, memory writes and dump words of each bring-up sequence.
module tb_prog_load_ctrl;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 10;
    localparam int REG_AW    = 5;
    localparam int DUMP_REGS = 6;
    localparam int TIMEOUT   = 64;
    localparam int CNT_W     = 16;
    localparam int NREGS     = 1 << REG_AW;

    logic              clk1 = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] prog_len = '0;
    logic              src_valid = 1'b0;
    logic [DATA_W-1:0] src_data = '0;
    logic              src_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              reg_we;
    logic [REG_AW-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic [DATA_W-1:0] reg_rdata;
    logic              cpu_run;
    logic              cpu_halted = 1'b0;
    logic              dump_valid;
    logic [REG_AW-1:0] dump_idx;
    logic [DATA_W-1:0] dump_data;
    logic              dump_ready = 1'b0;
    logic              busy;
    logic              done;
    logic              timed_out;
    logic [CNT_W-1:0]  cycles;
    logic [2:0]        dbg_state;

    prog_load_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW),
        .DUMP_REGS(DUMP_REGS), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .prog_len(prog_len),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .cpu_run(cpu_run), .cpu_halted(cpu_halted),
        .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data), .dump_ready(dump_ready),
        .busy(busy), .done(done), .timed_out(timed_out), .cycles(cycles), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk1 = ~clk1;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] tb_rf [NREGS];
    logic [DATA_W-1:0] res_v [NREGS];
    logic              res_en [NREGS];
    logic [DATA_W-1:0] exp_rf [NREGS];
    logic [DATA_W-1:0] prog_q[$];
    logic [DATA_W-1:0] exp_reg_q[$];
    logic [DATA_W-1:0] exp_mem_q[$];
    logic [DATA_W-1:0] exp_dump_q[$];
    int                mem_seen = 0;
    int                dump_seen = 0;
    int                halt_at = 0;
    int                run_n = 0;
    logic              exp_to = 1'b0;
    int                exp_cyc = 0;

    assign reg_rdata = tb_rf[reg_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor plus core model, both on the falling edge.
    always @(negedge clk1) begin
        if (rst_n) begin
            check("one_hot", 64'(int'(reg_we) + int'(mem_we) + int'(cpu_run) + int'(dump_valid) <= 1), 1);
            if (reg_we) begin
                if (exp_reg_q.size() == 0) check("reg_extra", 1, 0);
                else begin
                    logic [DATA_W-1:0] e;
                    e = exp_reg_q.pop_front();
                    check("reg_addr", reg_addr, e);
                    check("reg_wdata", reg_wdata, e);
                    tb_rf[reg_addr] = reg_wdata;
                end
            end
            if (mem_we) begin
                if (exp_mem_q.size() == 0) check("mem_extra", 1, 0);
                else begin
                    check("mem_addr", mem_addr, mem_seen);
                    check("mem_wdata", mem_wdata, exp_mem_q.pop_front());
                    mem_seen++;
                end
            end
            if (dump_valid) begin
                if (dump_seen >= exp_dump_q.size()) check("dump_extra", 1, 0);
                else begin
                    check("dump_idx", dump_idx, dump_seen);
                    check("dump_data", dump_data, exp_dump_q[dump_seen]);
                    if (dump_ready) dump_seen++;
                end
            end
        end
        if (rst_n && cpu_run) begin
            run_n++;
            cpu_halted = (run_n == halt_at);
            if (cpu_halted) begin
                for (int k = 0; k < NREGS; k++) if (res_en[k]) tb_rf[k] = res_v[k];
            end
        end else begin
            run_n = 0;
            cpu_halted = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_res();
        for (int k = 0; k < NREGS; k++) begin
            res_en[k] = 1'b0;
            res_v[k]  = '0;
        end
    endtask

    task automatic arm(input int h);
        exp_reg_q.delete();
        exp_mem_q.delete();
        exp_dump_q.delete();
        for (int k = 0; k < NREGS; k++) exp_reg_q.push_back(DATA_W'(k));
        foreach (prog_q[i]) exp_mem_q.push_back(prog_q[i]);
        halt_at = h;
        exp_to  = !(h != 0 && h <= TIMEOUT);
        exp_cyc = exp_to ? TIMEOUT : h;
        for (int k = 0; k < NREGS; k++) exp_rf[k] = (!exp_to && res_en[k]) ? res_v[k] : DATA_W'(k);
        for (int k = 0; k < DUMP_REGS; k++) exp_dump_q.push_back(exp_rf[k]);
        mem_seen  = 0;
        dump_seen = 0;
    endtask

    task automatic pulse_start(input int len);
        prog_len = ADDR_W'(len);
        start = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
    endtask

    task automatic load_words(input int vmode, input int stop_after);
        int i = 0;
        int n = 0;
        logic acc;
        while (i < prog_q.size() && i < stop_after && n < 400) begin
            case (vmode)
                0: src_valid = 1'b1;
                1: src_valid = (n % 2 == 0);
                default: src_valid = 1'($urandom_range(0, 1));
            endcase
            src_data = src_valid ? prog_q[i] : DATA_W'($urandom);
            @(negedge clk1);
            acc = src_valid && src_ready;
            @(posedge clk1); #1;
            n++;
            if (acc) i++;
        end
        src_valid = 1'b0;
        check("load_budget", 64'(n < 400), 1);
    endtask

    task automatic wait_done(input bit stall2, input bit rnd, input bit poke);
        int n = 0;
        int st = 0;
        bit poked = 1'b0;
        while (!done && n < 400) begin
            start = poke && !poked && cpu_run;
            if (start) poked = 1'b1;
            if (stall2 && dump_valid && dump_idx == 2 && st < 5) begin
                dump_ready = 1'b0;
                st++;
            end else begin
                dump_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            @(posedge clk1); #1;
            n++;
        end
        start = 1'b0;
        dump_ready = 1'b0;
        check("done_reached", 64'(n < 400), 1);
        if (stall2) check("stall_cycles", st, 5);
        if (poke) check("busy_start_sent", poked, 1);
    endtask

    task automatic run_case(input int vmode, input int h, input bit stall2, input bit rnd, input bit poke);
        arm(h);
        pulse_start(prog_q.size());
        load_words(vmode, 1 << 30);
        wait_done(stall2, rnd, poke);
        check("done", done, 1);
        check("busy_off", busy, 0);
        check("timed_out", timed_out, exp_to);
        check("cycles", cycles, exp_cyc);
        check("reg_writes_left", exp_reg_q.size(), 0);
        check("mem_writes", mem_seen, prog_q.size());
        check("dump_words", dump_seen, DUMP_REGS);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_run"}, cpu_run, 0);
        check({tag, "_outs"}, 64'(|{src_ready, mem_we, mem_addr, mem_wdata, reg_we, reg_addr, reg_wdata,
                                   dump_valid, dump_idx, dump_data, busy, done, timed_out, cycles}), 0);
    endtask

    task automatic abort_case(input bit in_run);
        int n = 0;
        prog_q.delete();
        for (int i = 0; i < 8; i++) prog_q.push_back(DATA_W'($urandom));
        clear_res();
        arm(0);
        pulse_start(8);
        if (!in_run) begin
            load_words(0, 3);
            check("pre_rst_ready", src_ready, 1);
        end else begin
            load_words(0, 100);
            while (!cpu_run && n < 50) begin
                @(posedge clk1); #1;
                n++;
            end
            repeat (3) begin
                @(posedge clk1); #1;
            end
            check("pre_rst_run", cpu_run, 1);
        end
        rst_n = 1'b0;
        #2;
        check_all_zero(in_run ? "rst_run" : "rst_load");
        @(posedge clk1); #1;
        @(posedge clk1); #1;
        rst_n = 1'b1;
        @(posedge clk1); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int k = 0; k < NREGS; k++) tb_rf[k] = '0;
        clear_res();
        repeat (2) @(posedge clk1);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk1); #1;

        // Reference program: R1=10, R2=20, R3=25, R4=R1+R2, R5=R4+R3, then HALT.
        prog_q = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                   32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        clear_res();
        res_en[1] = 1'b1; res_v[1] = 32'd10;
        res_en[2] = 1'b1; res_v[2] = 32'd20;
        res_en[3] = 1'b1; res_v[3] = 32'd25;
        res_en[4] = 1'b1; res_v[4] = 32'd30;
        res_en[5] = 1'b1; res_v[5] = 32'd55;
        run_case(0, 14, 1'b0, 1'b0, 1'b0);

        // No HALT: runs into the timeout.
        prog_q = '{32'h0ce77800};
        clear_res();
        run_case(0, 0, 1'b0, 1'b0, 1'b0);

        // Valid toggled every other cycle.
        prog_q.delete();
        for (int i = 0; i < 7; i++) prog_q.push_back(DATA_W'($urandom));
        run_case(1, 20, 1'b0, 1'b0, 1'b0);

        // Dump consumer stalls on word 2.
        prog_q = '{32'h11111111, 32'h22222222, 32'h33333333};
        res_en[2] = 1'b1; res_v[2] = 32'hdeadbeef;
        res_en[3] = 1'b1; res_v[3] = 32'h0badf00d;
        run_case(0, 10, 1'b1, 1'b0, 1'b0);

        // Reset mid-LOAD and mid-RUN, then a clean sequence from register 0.
        abort_case(1'b0);
        abort_case(1'b1);
        prog_q = '{32'h0000aaaa, 32'h0000bbbb, 32'h0000cccc, 32'h0000dddd};
        clear_res();
        res_en[0] = 1'b1; res_v[0] = 32'h12345678;
        run_case(0, 8, 1'b0, 1'b0, 1'b0);

        // prog_len=0, start while busy, halt coinciding with the timeout.
        prog_q.delete();
        clear_res();
        res_en[4] = 1'b1; res_v[4] = 32'h00c0ffee;
        run_case(0, TIMEOUT, 1'b0, 1'b0, 1'b1);

        // Randomised sequences.
        for (int r = 0; r < 5; r++) begin
            int len;
            len = $urandom_range(1, 12);
            prog_q.delete();
            for (int i = 0; i < len; i++) prog_q.push_back(DATA_W'($urandom));
            clear_res();
            for (int i = 0; i < 3; i++) begin
                int k;
                k = $urandom_range(1, 7);
                res_en[k] = 1'b1;
                res_v[k]  = DATA_W'($urandom);
            end
            run_case($urandom_range(0, 2), $urandom_range(3, 70), 1'b0, 1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
